top_sobel: RTL and testbench
============================

TOP_SOBEL -- requirements
Module: top_sobel

Interface
REQ-001 Parameter PX_SIZE, default 8, pixel width in bits.
REQ-002 Parameter IMAGE_WIDTH, default 640, pixels per line.
REQ-003 Parameter IMAGE_HEIGHT, default 480, lines per frame.
REQ-004 Parameter THRESHOLD, default 128, binarization level; used only with SOBEL_THRESHOLD_EN.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 input_data  input  PX_SIZE  grey pixel, raster order, left-to-right then top-to-bottom.
REQ-008 input_data_valid  input  1  input_data valid this cycle; no backpressure.
REQ-009 output_data  output  PX_SIZE  edge-magnitude pixel.
REQ-010 output_data_valid  output  1  output_data valid this cycle.

Function
REQ-011 Each cycle with input_data_valid=1 consumes one pixel; exactly one output pixel per input pixel, in the same raster order.
REQ-012 Fixed latency: output_data_valid high exactly 2 clk cycles after the cycle that input_data_valid was sampled high; gaps in input valid reproduce as identical gaps in output valid.
REQ-013 Column counter 0..IMAGE_WIDTH-1 and row counter 0..IMAGE_HEIGHT-1 advance only on valid input; column wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame, so frames run back-to-back.
REQ-014 Two line buffers of IMAGE_WIDTH x PX_SIZE each hold the previous two lines; each buffer is written only on valid input.
REQ-015 3x3 window p[i][j]: i=0 oldest line, i=2 current line; j=2 is the current column.
REQ-016 Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20); Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02); both signed, at least PX_SIZE+4 bits, with no overflow.
REQ-017 Magnitude M = |Gx| + |Gy| (at least PX_SIZE+5 bits); output saturates to 2^PX_SIZE-1 when M exceeds it.
REQ-018 Output for input position (r,c) is the Sobel value of the window centred on (r-1,c-1), so the output image is shifted one line down and one column right.
REQ-019 Output is 0 when r<2 or c<2; windows never combine pixels from different lines or frames.
REQ-020 A valid input arriving during the 2-cycle pipeline drain is accepted normally; continuous valid is supported indefinitely.

Reset
REQ-021 While resetn=0: output_data=0, output_data_valid=0, counters=0, pipeline valid flags cleared, window registers=0.
REQ-022 Line-buffer contents are not reset; REQ-019 masking makes stale data invisible.
REQ-023 Reset mid-frame aborts the frame; the first valid input after release is pixel (0,0); no output from before the reset appears afterward.

Configuration
REQ-024 With macro SOBEL_THRESHOLD_EN defined, output_data = 2^PX_SIZE-1 when saturated M >= THRESHOLD, else 0; masked positions per REQ-019 are still 0.
REQ-025 Without SOBEL_THRESHOLD_EN, output_data is the saturated magnitude of REQ-017, and no threshold logic is synthesized.

Verification
REQ-026 Uniform image, all pixels 100 -> 307200 outputs, all 0; output_data_valid lags input_data_valid by exactly 2 cycles.
REQ-027 Vertical step, pixels 0 for c<320 and 255 for c>=320 -> output 255 at columns 320..321 for rows >=2; 0 elsewhere.
REQ-028 Horizontal step, 0 for r<240 and 10 for r>=240 -> output 40 at rows 240..241, columns >=2; 0 elsewhere.
REQ-029 Valid toggled 1,0,1,0 through the frame -> same outputs as the continuous-valid run; valid pattern reproduced 2 cycles later.
REQ-030 resetn pulsed low at pixel (100,50), then a full frame sent -> outputs identical to a clean run; valid low during reset.
REQ-031 SOBEL_THRESHOLD_EN defined, THRESHOLD=128, horizontal step of REQ-028 -> all outputs 0; with step height 40 -> 255 at rows 240..241, columns >=2.

Source files
------------

// File: rtl/top_sobel_if.sv
// Pixel stream bundle for top_sobel: raster-order input and edge-magnitude output.
// The master drives pixels in and collects results; the slave is the filter.
interface top_sobel_if #(
   parameter int PX_SIZE = 8
);
   logic [PX_SIZE-1:0] input_data;
   logic               input_data_valid;
   logic [PX_SIZE-1:0] output_data;
   logic               output_data_valid;

   modport master (
      output input_data,
      output input_data_valid,
      input  output_data,
      input  output_data_valid
   );

   modport slave (
      input  input_data,
      input  input_data_valid,
      output output_data,
      output output_data_valid
   );
endinterface

// File: rtl/top_sobel.sv
// Streaming 3x3 Sobel edge filter with two line buffers and fixed 2-cycle latency.
// Optional binarization enabled by defining SOBEL_THRESHOLD_EN.
module top_sobel #(
   parameter int PX_SIZE      = 8,
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int THRESHOLD    = 128
) (
   input  logic       clk,
   input  logic       resetn,
   top_sobel_if.slave bus
);
   localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int GW = PX_SIZE + 4;
   localparam int MW = PX_SIZE + 5;
   localparam logic [PX_SIZE-1:0] PX_MAX = '1;

   if (THRESHOLD < 0 || THRESHOLD > (2 ** PX_SIZE)) begin : g_thr_chk
      $error("top_sobel: THRESHOLD out of pixel range");
   end

   logic [PX_SIZE-1:0] r_lb0 [IMAGE_WIDTH];
   logic [PX_SIZE-1:0] r_lb1 [IMAGE_WIDTH];
   logic [PX_SIZE-1:0] r_win [3][3];
   logic [CW-1:0]      r_col;
   logic [RW-1:0]      r_row;
   logic               r_s1_valid;
   logic               r_s1_mask;
   logic [PX_SIZE-1:0] r_out;
   logic               r_out_valid;

   logic               w_in_valid;
   logic [PX_SIZE-1:0] w_in_data;
   logic [PX_SIZE-1:0] w_lb0_rd;
   logic [PX_SIZE-1:0] w_lb1_rd;
   logic               w_col_last;
   logic               w_row_last;

   assign w_in_valid = bus.input_data_valid;
   assign w_in_data  = bus.input_data;
   assign w_lb0_rd   = r_lb0[r_col];
   assign w_lb1_rd   = r_lb1[r_col];
   assign w_col_last = (r_col == CW'(IMAGE_WIDTH - 1));
   assign w_row_last = (r_row == RW'(IMAGE_HEIGHT - 1));

   // lb0 holds the previous line, lb1 the one before it; never reset
   always_ff @(posedge clk) begin
      if (w_in_valid) begin
         r_lb0[r_col] <= w_in_data;
         r_lb1[r_col] <= w_lb0_rd;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col      <= '0;
         r_row      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_mask  <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               r_win[i][j] <= '0;
            end
         end
      end else begin
         r_s1_valid <= w_in_valid;
         if (w_in_valid) begin
            r_s1_mask <= (r_col < CW'(2)) || (r_row < RW'(2));
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
            for (int i = 0; i < 3; i++) begin
               r_win[i][0] <= r_win[i][1];
               r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb1_rd;
            r_win[1][2] <= w_lb0_rd;
            r_win[2][2] <= w_in_data;
         end
      end
   end

   function automatic logic signed [GW-1:0] ext(input logic [PX_SIZE-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   logic signed [GW-1:0] w_gx;
   logic signed [GW-1:0] w_gy;
   logic [GW-1:0]        w_ax;
   logic [GW-1:0]        w_ay;
   logic [MW-1:0]        w_mag;
   logic [PX_SIZE-1:0]   w_sat;
   logic [PX_SIZE-1:0]   w_px;

   assign w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
               - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
   assign w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
               - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));
   assign w_ax  = w_gx[GW-1] ? GW'(-w_gx) : GW'(w_gx);
   assign w_ay  = w_gy[GW-1] ? GW'(-w_gy) : GW'(w_gy);
   assign w_mag = MW'(w_ax) + MW'(w_ay);
   assign w_sat = (w_mag > MW'(PX_MAX)) ? PX_MAX : w_mag[PX_SIZE-1:0];

`ifdef SOBEL_THRESHOLD_EN
   assign w_px = (MW'(w_sat) >= MW'(THRESHOLD)) ? PX_MAX : '0;
`else
   assign w_px = w_sat;
`endif

   // border windows span lines or frames, so they are forced to zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out <= r_s1_mask ? '0 : w_px;
         end
      end
   end

   assign bus.output_data       = r_out;
   assign bus.output_data_valid = r_out_valid;
endmodule

// File: tb/tb_top_sobel.sv
// Scoreboard bench for top_sobel on a reduced 16x12 frame.
// Reference Sobel is computed from a full frame image, not from line buffers.
module tb_top_sobel;
   localparam int PX  = 8;
   localparam int W   = 16;
   localparam int H   = 12;
   localparam int THR = 128;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   top_sobel_if #(.PX_SIZE(PX)) bus ();

   top_sobel #(
      .PX_SIZE     (PX),
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .THRESHOLD   (THR)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int img [H][W];
   int sbq [$];
   int n_cmp = 0;
   int n_err = 0;
   bit h1 = 1'b0;
   bit h2 = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int exp_px(input int r, input int c);
      int gx, gy, m;
      if (r < 2 || c < 2) return 0;
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      m = iabs(gx) + iabs(gy);
      if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
      return (m >= THR) ? 255 : 0;
`else
      return m;
`endif
   endfunction

   task automatic fill(input int pat);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            case (pat)
               0:       img[r][c] = 100;
               1:       img[r][c] = (c >= W/2) ? 255 : 0;
               2:       img[r][c] = (r >= H/2) ? 10 : 0;
               3:       img[r][c] = (r >= H/2) ? 40 : 0;
               default: img[r][c] = int'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   task automatic drive(input int d, input bit v);
      @(posedge clk);
      #1;
      bus.input_data       = PX'(d);
      bus.input_data_valid = v;
   endtask

   // mode 0: continuous, 1: toggled 1,0, 2: random gaps; stop<0 sends all
   task automatic send_frame(input int pat, input int mode, input int stop);
      fill(pat);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (stop >= 0 && r*W + c == stop) return;
            sbq.push_back(exp_px(r, c));
            drive(img[r][c], 1'b1);
            if (mode == 1) begin
               drive(int'($urandom_range(0, 255)), 1'b0);
            end else if (mode == 2) begin
               repeat ($urandom_range(0, 2)) drive(int'($urandom_range(0, 255)), 1'b0);
            end
         end
      end
   endtask

   always @(negedge clk) begin : mon
      int e;
      if (!resetn) begin
         chk("rst_valid", int'(bus.output_data_valid), 0);
         chk("rst_data", int'(bus.output_data), 0);
         h1 = 1'b0;
         h2 = 1'b0;
         sbq.delete();
      end else begin
         chk("latency", int'(bus.output_data_valid), int'(h2));
         if (bus.output_data_valid) begin
            if (sbq.size() == 0) begin
               chk("extra_out", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("pixel", int'(bus.output_data), e);
            end
         end
         h2 = h1;
         h1 = bus.input_data_valid;
      end
   end

   initial begin
      bus.input_data       = '0;
      bus.input_data_valid = 1'b0;
      resetn               = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;

      send_frame(0, 0, -1);
      send_frame(1, 0, -1);
      send_frame(2, 0, -1);
      send_frame(3, 0, -1);
      send_frame(4, 1, -1);
      send_frame(4, 2, -1);

      send_frame(4, 0, 5*W + 7);
      @(posedge clk);
      #1;
      resetn               = 1'b0;
      bus.input_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      send_frame(4, 0, -1);
      send_frame(1, 2, -1);

      drive(0, 1'b0);
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drain", sbq.size(), 0);
      chk("idle_valid", int'(bus.output_data_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
